// File: rtl/cons_alloc.sv
// cons_alloc: heap writer for the Lisp core.
//
// Accepts one allocation request at a time (NUMBER or CONS), bump-allocates
// it at free_ptr and streams the cell words to the RAM write port:
//   NUMBER = {TAG_NUMBER, value}        (2 words)
//   CONS   = {TAG_CONS, car, cdr}       (3 words)
// A request that would cross HEAP_LIMIT is refused with resp_oom and writes
// nothing.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   heap_reset               rewind free_ptr to HEAP_BASE (honoured in IDLE only)
//   req_valid / req_ready    request handshake
//   req_kind                 0 = NUMBER, 1 = CONS
//   req_car, req_cdr         NUMBER value / CONS car, CONS cdr
//   resp_valid               one-cycle completion pulse
//   resp_addr, resp_oom      cell base address (0 on OOM), out-of-memory flag
//   mem_we, mem_addr,        RAM write port
//   mem_wdata
//   free_ptr                 next free heap word
module cons_alloc #(
  parameter int unsigned            DATA_WIDTH = 16,
  parameter int unsigned            ADDR_WIDTH = 10,
  parameter int unsigned            HEAP_BASE  = 0,
  parameter int unsigned            HEAP_LIMIT = 1024,
  parameter logic [DATA_WIDTH-1:0]  TAG_NUMBER = 'h0001,
  parameter logic [DATA_WIDTH-1:0]  TAG_CONS   = 'h0002
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  heap_reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_kind,
  input  logic [DATA_WIDTH-1:0] req_car,
  input  logic [DATA_WIDTH-1:0] req_cdr,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_addr,
  output logic                  resp_oom,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] free_ptr
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(HEAP_BASE);
  // One extra bit so free_ptr + size never wraps before the limit compare.
  localparam logic [ADDR_WIDTH:0]   LimitExt = (ADDR_WIDTH + 1)'(HEAP_LIMIT);

  typedef enum logic [2:0] {StIdle, StWTag, StWCar, StWCdr, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   free_ptr_q, free_ptr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic                    kind_q, kind_d;
  logic [DATA_WIDTH-1:0]   car_q, car_d;
  logic [DATA_WIDTH-1:0]   cdr_q, cdr_d;
  logic                    oom_q, oom_d;

  logic [ADDR_WIDTH:0]     req_size;
  logic                    req_fits;
  logic [ADDR_WIDTH-1:0]   cell_size;

  assign req_size  = req_kind ? (ADDR_WIDTH + 1)'(3) : (ADDR_WIDTH + 1)'(2);
  assign req_fits  = ({1'b0, free_ptr_q} + req_size) <= LimitExt;
  assign cell_size = kind_q ? ADDR_WIDTH'(3) : ADDR_WIDTH'(2);
  assign free_ptr  = free_ptr_q;

  always_comb begin
    state_d    = state_q;
    free_ptr_d = free_ptr_q;
    base_d     = base_q;
    kind_d     = kind_q;
    car_d      = car_q;
    cdr_d      = cdr_q;
    oom_d      = oom_q;

    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_addr  = '0;
    resp_oom   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      StIdle: begin
        // A request arriving during rst would be lost, so never advertise ready.
        req_ready = !heap_reset && !rst;
        if (heap_reset) begin
          free_ptr_d = BaseAddr;
        end else if (req_valid && req_ready) begin
          kind_d = req_kind;
          car_d  = req_car;
          cdr_d  = req_cdr;
          base_d = free_ptr_q;
          oom_d  = !req_fits;
          state_d = req_fits ? StWTag : StResp;
        end
      end
      StWTag: begin
        mem_we    = 1'b1;
        mem_addr  = base_q;
        mem_wdata = kind_q ? TAG_CONS : TAG_NUMBER;
        state_d   = StWCar;
      end
      StWCar: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(1);
        mem_wdata = car_q;
        state_d   = kind_q ? StWCdr : StResp;
      end
      StWCdr: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(2);
        mem_wdata = cdr_q;
        state_d   = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_oom   = oom_q;
        resp_addr  = oom_q ? '0 : DATA_WIDTH'(base_q);
        if (!oom_q) begin
          free_ptr_d = base_q + cell_size;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      free_ptr_q <= BaseAddr;
      base_q     <= '0;
      kind_q     <= 1'b0;
      car_q      <= '0;
      cdr_q      <= '0;
      oom_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      free_ptr_q <= free_ptr_d;
      base_q     <= base_d;
      kind_q     <= kind_d;
      car_q      <= car_d;
      cdr_q      <= cdr_d;
      oom_q      <= oom_d;
    end
  end

endmodule

// File: tb/tb_cons_alloc.sv
// Bench for cons_alloc: a bump-allocator model predicts every RAM write and
// response (with its cycle), a negedge monitor pops and compares.
module tb_cons_alloc;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 6;
  localparam int          BASE  = 4;
  localparam int          LIMIT = 44;
  localparam logic [15:0] TAG_N = 16'h0001;
  localparam logic [15:0] TAG_C = 16'h0002;
  localparam logic [15:0] NIL   = 16'h0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          heap_reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_kind = 1'b0;
  logic [DW-1:0] req_car = '0;
  logic [DW-1:0] req_cdr = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_addr;
  logic          resp_oom;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] free_ptr;

  cons_alloc #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .HEAP_BASE  (BASE),
    .HEAP_LIMIT (LIMIT),
    .TAG_NUMBER (TAG_N),
    .TAG_CONS   (TAG_C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .heap_reset (heap_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_car    (req_car),
    .req_cdr    (req_cdr),
    .resp_valid (resp_valid),
    .resp_addr  (resp_addr),
    .resp_oom   (resp_oom),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .free_ptr   (free_ptr)
  );

  always #5 clk = ~clk;

  // Event kinds: 0 = RAM write, 1 = good response, 2 = OOM response, 3 = heap rewind.
  typedef struct {
    int cyc;
    int typ;
    int addr;
    int data;
    int fp;
  } ev_t;

  ev_t q[$];
  ev_t e_mon;
  int  cyc = 0;
  int  next_idle = 0;
  int  model_fp = BASE;
  int  fp_vis = BASE;
  bit  started = 1'b0;
  int  total = 0;
  int  bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every cycle against the model's timeline.
  always @(negedge clk) begin
    bit ew;
    bit er;
    ew = 1'b0;
    er = 1'b0;
    if (rst) begin
      chk("ready_in_rst", 32'(req_ready), 32'(0));
    end else if (started) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("event_missed", 32'(q[0].cyc), 32'(cyc));
        void'(q.pop_front());
      end
      chk("free_ptr", 32'(free_ptr), 32'(fp_vis));
      chk("req_ready", 32'(req_ready), 32'(cyc >= next_idle && !heap_reset));
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e_mon = q.pop_front();
        case (e_mon.typ)
          0: begin
            ew = 1'b1;
            chk("mem_addr", 32'(mem_addr), 32'(e_mon.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_mon.data));
          end
          1, 2: begin
            er = 1'b1;
            chk("resp_addr", 32'(resp_addr), 32'(e_mon.addr));
            chk("resp_oom", 32'(resp_oom), 32'(e_mon.typ == 2));
            fp_vis = e_mon.fp;
          end
          default: fp_vis = e_mon.fp;
        endcase
      end
      chk("mem_we", 32'(mem_we), 32'(ew));
      chk("resp_valid", 32'(resp_valid), 32'(er));
      if (!er) chk("resp_oom_idle", 32'(resp_oom), 32'(0));
    end
  end

  task automatic scramble();
    req_kind = 1'($urandom);
    req_car  = 16'($urandom);
    req_cdr  = 16'($urandom);
  endtask

  // Entered and left at posedge+1. Returns the accept cycle; on return the
  // DUT is one cycle past accept. hold keeps req_valid high for a follow-on issue.
  task automatic issue(input bit kind, input logic [15:0] car, input logic [15:0] cdr,
                       input bit hold, output int acc);
    int size;
    int nid;
    req_valid = 1'b1;
    while (cyc < next_idle) begin
      scramble();
      @(posedge clk); #1;
    end
    req_kind = kind;
    req_car  = car;
    req_cdr  = cdr;
    acc  = cyc;
    size = kind ? 3 : 2;
    if (model_fp + size <= LIMIT) begin
      q.push_back('{acc + 1, 0, model_fp, int'(kind ? TAG_C : TAG_N), 0});
      q.push_back('{acc + 2, 0, model_fp + 1, int'(car), 0});
      if (kind) q.push_back('{acc + 3, 0, model_fp + 2, int'(cdr), 0});
      q.push_back('{acc + size + 1, 1, model_fp, 0, model_fp + size});
      model_fp = model_fp + size;
      nid = acc + size + 2;
    end else begin
      q.push_back('{acc + 1, 2, 0, 0, model_fp});
      nid = acc + 2;
    end
    @(posedge clk); #1;
    next_idle = nid;
    req_valid = hold;
    scramble();
  endtask

  task automatic hrst(input bit with_req);
    heap_reset = 1'b1;
    req_valid  = with_req;
    scramble();
    if (cyc >= next_idle) begin
      q.push_back('{cyc, 3, 0, 0, BASE});
      model_fp = BASE;
    end
    @(posedge clk); #1;
    heap_reset = 1'b0;
    req_valid  = 1'b0;
  endtask

  task automatic gap();
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    fp_vis    = BASE;
    model_fp  = BASE;
    next_idle = cyc;
  endtask

  initial begin
    int acc;
    int act;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    fp_vis    = BASE;
    model_fp  = BASE;
    next_idle = cyc;
    started   = 1'b1;
    @(negedge clk);
    chk("rst_resp_addr", 32'(resp_addr), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_free_ptr", 32'(free_ptr), 32'(BASE));
    @(posedge clk); #1;

    // Single CONS right after reset.
    issue(1'b1, 16'h0003, NIL, 1'b0, acc);

    // (+ 5 3) image: NUMBER 5, NUMBER 3, CONS(3,NIL), CONS(5,..), CONS(prim,..).
    hrst(1'b0);
    issue(1'b0, 16'h0005, 16'hdead, 1'b0, acc);
    issue(1'b0, 16'h0003, 16'hbeef, 1'b0, acc);
    issue(1'b1, 16'(BASE + 2), NIL, 1'b0, acc);
    issue(1'b1, 16'(BASE), 16'(BASE + 4), 1'b0, acc);
    issue(1'b1, 16'h0009, 16'(BASE + 7), 1'b0, acc);

    // Fill to 43, then NUMBER/CONS overflow; then fill exactly to the limit.
    hrst(1'b0);
    for (int i = 0; i < 13; i++) issue(1'b1, 16'($urandom), 16'($urandom), 1'b0, acc);
    issue(1'b0, 16'h0007, NIL, 1'b0, acc);
    issue(1'b1, 16'h0007, NIL, 1'b0, acc);
    hrst(1'b0);
    for (int i = 0; i < 20; i++) issue(1'b0, 16'($urandom), NIL, 1'b0, acc);
    issue(1'b0, 16'h0007, NIL, 1'b0, acc);

    // Back-to-back CONS with req_valid held and inputs churning.
    hrst(1'b0);
    for (int i = 0; i < 4; i++) issue(1'b1, 16'($urandom), 16'($urandom), i < 3, acc);

    // Reset while writing the car word; then allocate again from the base.
    issue(1'b1, 16'h0011, 16'h0022, 1'b0, acc);
    gap();
    do_rst();
    gap();
    issue(1'b0, 16'h0007, NIL, 1'b0, acc);

    // heap_reset beats a same-cycle request; heap_reset while busy is ignored.
    hrst(1'b1);
    gap();
    issue(1'b0, 16'h0042, NIL, 1'b0, acc);
    issue(1'b1, 16'h0043, 16'h0044, 1'b0, acc);
    hrst(1'b0);
    issue(1'b0, 16'h0045, NIL, 1'b0, acc);

    // Random traffic.
    act = int'($urandom_range(0, 7));
    for (int n = 0; n < 300; n++) begin
      int nxt;
      nxt = int'($urandom_range(0, 7));
      if (act == 0) hrst(1'($urandom));
      else if (act == 1) gap();
      else issue(1'($urandom), 16'($urandom), 16'($urandom), nxt >= 2, acc);
      act = nxt;
    end
    req_valid = 1'b0;

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) chk("drain", 32'(q.size()), 32'(0));
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
